// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states, flag layout.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_MULL = 4'd10,
        ALU_MULH = 4'd11,
        ALU_DIV  = 4'd12,
        ALU_MOD  = 4'd13,
        ALU_INC  = 4'd14,
        ALU_PASS = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

    localparam int unsigned FLAG_Z   = 0;
    localparam int unsigned FLAG_C   = 1;
    localparam int unsigned FLAG_N   = 2;
    localparam int unsigned FLAG_V   = 3;
    localparam int unsigned FLAG_E   = 4;
    localparam int unsigned FLAG_NUM = 5;

    typedef logic [FLAG_NUM-1:0] alu_flags_t;

    function automatic logic is_muldiv(input alu_op_e op);
        return (op == ALU_MULL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

    function automatic alu_flags_t pack_flags(input logic z, input logic c, input logic n,
                                              input logic v, input logic e);
        alu_flags_t f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        f[FLAG_E] = e;
        return f;
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned unit: shift-add multiply and restoring divide, one bit per clock.
// o_done is high once the W iterations have finished and stays high until the unit is idle.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_mul,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_mul;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;

    logic [W:0]    w_sum;
    logic [W:0]    w_rem_sh;
    logic          w_ge;
    logic [W-1:0]  w_diff;

    // r_hi:r_lo is the product accumulator (mul) or remainder:quotient (div)
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_rem_sh = {r_hi, r_lo[W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_diff   = W'(w_rem_sh - {1'b0, r_b});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_mul  <= 1'b0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (i_start) begin
            r_cnt  <= CW'(W);
            r_busy <= 1'b1;
            r_mul  <= i_mul;
            r_b    <= i_b;
            r_hi   <= '0;
            r_lo   <= i_a;
        end else if (r_busy && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_mul) begin
                {r_hi, r_lo} <= {w_sum, r_lo[W-1:1]};
            end else if (w_ge) begin
                r_hi <= w_diff;
                r_lo <= {r_lo[W-2:0], 1'b1};
            end else begin
                r_hi <= w_rem_sh[W-1:0];
                r_lo <= {r_lo[W-2:0], 1'b0};
            end
        end else if (o_done) begin
            r_busy <= 1'b0;
        end
    end

    assign o_done = r_busy && (r_cnt == '0);
    assign o_lo   = r_lo;
    assign o_hi   = r_hi;

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: valid/ready in, registered result + flags out.
// ALU_MULDIV_EN enables the iterative mul/div unit; without it ops 10-13 return 0 with err set.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 8,
    parameter int unsigned OPCODE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_WIDTH-1:0]   operand1,
    input  logic [WORD_WIDTH-1:0]   operand2,
    input  logic [OPCODE_WIDTH-1:0] opCode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_WIDTH-1:0]   result,
    output logic                    zero_flag,
    output logic                    carry_flag,
    output logic                    negative_flag,
    output logic                    overflow_flag,
    output logic                    err_flag,
    output logic                    busy
);

    localparam int unsigned W = WORD_WIDTH;

    alu_state_e  r_state;
    logic [W-1:0] r_result;
    alu_flags_t  r_flags;

    alu_op_e     w_op;
    logic        w_accept;
    logic [W:0]  w_add;
    logic [W-1:0] w_sub;
    logic [W:0]  w_inc;
    logic [W:0]  w_shl;
    logic [W:0]  w_shr;
    logic [W:0]  w_sra;
    logic        w_lt;
    logic [W-1:0] w_res;
    logic        w_carry;
    logic        w_ovf;
    logic        w_err;

    assign w_op     = alu_op_e'(opCode);
    assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;

    // Shifts carry an extra bit so the last bit shifted out lands in bit W / bit 0
    assign w_add = {1'b0, operand1} + {1'b0, operand2};
    assign w_sub = W'(operand1 - operand2);
    assign w_inc = {1'b0, operand1} + (W + 1)'(1);
    assign w_shl = {1'b0, operand1} << operand2;
    assign w_shr = {operand1, 1'b0} >> operand2;
    assign w_sra = $signed({operand1, 1'b0}) >>> operand2;
    assign w_lt  = (operand1 < operand2);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (w_op)
            ALU_ADD: begin
                w_res   = w_add[W-1:0];
                w_carry = w_add[W];
                w_ovf   = (operand1[W-1] == operand2[W-1]) && (w_add[W-1] != operand1[W-1]);
            end
            ALU_SUB: begin
                w_res   = w_sub;
                w_carry = w_lt;
                w_ovf   = (operand1[W-1] != operand2[W-1]) && (w_sub[W-1] != operand1[W-1]);
            end
            ALU_AND: w_res = operand1 & operand2;
            ALU_OR:  w_res = operand1 | operand2;
            ALU_XOR: w_res = operand1 ^ operand2;
            ALU_NOT: w_res = ~operand1;
            ALU_SHL: begin
                w_res   = w_shl[W-1:0];
                w_carry = w_shl[W];
            end
            ALU_SHR: begin
                w_res   = w_shr[W:1];
                w_carry = w_shr[0];
            end
            ALU_SRA: begin
                w_res   = w_sra[W:1];
                w_carry = w_sra[0];
            end
            ALU_SLT: begin
                w_res   = W'(w_lt);
                w_carry = w_lt;
            end
            ALU_INC: begin
                w_res   = w_inc[W-1:0];
                w_carry = w_inc[W];
                w_ovf   = !operand1[W-1] && w_inc[W-1];
            end
            ALU_PASS: w_res = operand2;
            default:  w_err = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic         r_sel_hi;
    logic         r_is_mul;
    logic         r_div0;
    logic         w_md_done;
    logic [W-1:0] w_md_lo;
    logic [W-1:0] w_md_hi;
    logic [W-1:0] w_md_res;

    alu_muldiv #(.W(W)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_accept && is_muldiv(w_op)),
        .i_mul  ((w_op == ALU_MULL) || (w_op == ALU_MULH)),
        .i_a    (operand1),
        .i_b    (operand2),
        .o_done (w_md_done),
        .o_lo   (w_md_lo),
        .o_hi   (w_md_hi)
    );

    assign w_md_res = r_sel_hi ? w_md_hi : w_md_lo;
`endif

    // Handshake FSM; a new accept from DONE takes priority over returning to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_flags  <= '0;
`ifdef ALU_MULDIV_EN
            r_sel_hi <= 1'b0;
            r_is_mul <= 1'b0;
            r_div0   <= 1'b0;
`endif
        end else if (w_accept) begin
`ifdef ALU_MULDIV_EN
            if (is_muldiv(w_op)) begin
                r_state  <= S_EXEC;
                r_sel_hi <= (w_op == ALU_MULH) || (w_op == ALU_MOD);
                r_is_mul <= (w_op == ALU_MULL) || (w_op == ALU_MULH);
                r_div0   <= (operand2 == '0);
            end else
`endif
            begin
                r_state  <= S_DONE;
                r_result <= w_res;
                r_flags  <= pack_flags(w_res == '0, w_carry, w_res[W-1], w_ovf, w_err);
            end
        end else begin
            case (r_state)
`ifdef ALU_MULDIV_EN
                S_EXEC: begin
                    if (w_md_done) begin
                        r_state  <= S_DONE;
                        r_result <= w_md_res;
                        r_flags  <= pack_flags(w_md_res == '0, 1'b0, w_md_res[W-1],
                                               r_is_mul && (w_md_hi != '0),
                                               !r_is_mul && r_div0);
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign out_valid     = (r_state == S_DONE);
    assign busy          = (r_state == S_EXEC);
    assign result        = r_result;
    assign zero_flag     = r_flags[FLAG_Z];
    assign carry_flag    = r_flags[FLAG_C];
    assign negative_flag = r_flags[FLAG_N];
    assign overflow_flag = r_flags[FLAG_V];
    assign err_flag      = r_flags[FLAG_E];

endmodule
